// File: rtl/banked_mem_pkg.sv
// Shared definitions for the banked RAM: write-mode encodings and address sizing.
package banked_mem_pkg;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;
    localparam int WM_NO_CHANGE   = 2;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // A single-bank build still carries one select bit so out-of-range stays reachable.
    function automatic int addr_width(input int bank_aw, input int num_banks);
        int sel_w;
        sel_w = clog2(num_banks);
        if (sel_w < 1) begin
            sel_w = 1;
        end
        return bank_aw + sel_w;
    endfunction

endpackage

// File: rtl/banked_mem_if.sv
// Access bus of the banked RAM: request, write data, read data and error status.
interface banked_mem_if #(
    parameter int DATA_W = 8,
    parameter int PAR_W  = 1,
    parameter int ADDR_W = 13,
    parameter int ERR_W  = 8
);
    logic              en;
    logic              we;
    logic              ssr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] di;
    logic [PAR_W-1:0]  dip;
    logic              err_clr;
    logic [DATA_W-1:0] dout;
    logic [PAR_W-1:0]  doutp;
    logic              rd_valid;
    logic              addr_err;
    logic [ERR_W-1:0]  err_cnt;

    modport master (
        output en, we, ssr, addr, di, dip, err_clr,
        input  dout, doutp, rd_valid, addr_err, err_cnt
    );

    modport slave (
        input  en, we, ssr, addr, di, dip, err_clr,
        output dout, doutp, rd_valid, addr_err, err_cnt
    );
endinterface

// File: rtl/banked_mem_mem_bank.sv
// One single-port RAM bank with a registered output that honours the write mode
// and a synchronous set/reset value.
module mem_bank
    import banked_mem_pkg::*;
#(
    parameter int                WORD_W     = 9,
    parameter int                AW         = 11,
    parameter int                WRITE_MODE = WM_READ_FIRST,
    parameter logic [WORD_W-1:0] SRVAL      = '0
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic              ssr_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] di_i,
    output logic [WORD_W-1:0] do_o
);

    logic [WORD_W-1:0] mem_q [2**AW];
    logic [WORD_W-1:0] rdata_q;

    // No reset here so the array and its output register map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= di_i;
            end
            if (ssr_i) begin
                rdata_q <= SRVAL;
            end else if (!we_i) begin
                rdata_q <= mem_q[addr_i];
            end else if (WRITE_MODE == WM_READ_FIRST) begin
                rdata_q <= mem_q[addr_i];
            end else if (WRITE_MODE == WM_WRITE_FIRST) begin
                rdata_q <= di_i;
            end
        end
    end

    assign do_o = rdata_q;

endmodule

// File: rtl/banked_mem.sv
// Multi-bank single-port RAM: address decode, registered bank-select mux,
// optional output register and saturating out-of-range access counter.
module banked_mem
    import banked_mem_pkg::*;
#(
    parameter int          DATA_W     = 8,
    parameter int          PAR_W      = 1,
    parameter int          BANK_AW    = 11,
    parameter int          NUM_BANKS  = 3,
    parameter int          OUT_REG    = 1,
    parameter int          WRITE_MODE = WM_READ_FIRST,
    parameter int unsigned SRVAL      = 0,
    parameter int          ERR_W      = 8
) (
    input logic         clk_i,
    input logic         rst_n_i,
    banked_mem_if.slave bus
);

    localparam int ADDR_W = addr_width(BANK_AW, NUM_BANKS);
    localparam int BANK_W = ADDR_W - BANK_AW;
    localparam int WORD_W = DATA_W + PAR_W;
    localparam logic [WORD_W-1:0] SRVAL_W     = WORD_W'(SRVAL);
    localparam logic [BANK_W:0]   NUM_BANKS_W = (BANK_W + 1)'(NUM_BANKS);

    logic [BANK_W-1:0]    bank_idx;
    logic [BANK_AW-1:0]   bank_off;
    logic                 in_range;
    logic                 acc_rd;
    logic                 acc_load;
    logic                 acc_oor;
    logic [NUM_BANKS-1:0] bank_en;
    logic [WORD_W-1:0]    bank_do [NUM_BANKS];
    logic [WORD_W-1:0]    mux_word;
    logic [WORD_W-1:0]    dout_word;

    logic [BANK_W-1:0]    sel_q;
    logic                 ld1_q;
    logic                 rv1_q;
    logic                 err1_q;
    logic                 rv2_q;
    logic                 err2_q;
    logic                 ok_q;
    logic [WORD_W-1:0]    out_q;
    logic [ERR_W-1:0]     cnt_q;
    logic [ERR_W-1:0]     cnt_d;

    assign bank_idx = bus.addr[ADDR_W-1:BANK_AW];
    assign bank_off = bus.addr[BANK_AW-1:0];
    assign in_range = ({1'b0, bank_idx} < NUM_BANKS_W);
    assign acc_oor  = bus.en && !in_range;
    assign acc_rd   = bus.en && in_range && !bus.we && !bus.ssr;

    // A no-change write leaves its bank register untouched, so the select must not follow it.
    assign acc_load = bus.en && in_range &&
                      (!bus.we || bus.ssr || (WRITE_MODE != WM_NO_CHANGE));

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_en[b] = bus.en && in_range && (bank_idx == BANK_W'(b));

        mem_bank #(
            .WORD_W     (WORD_W),
            .AW         (BANK_AW),
            .WRITE_MODE (WRITE_MODE),
            .SRVAL      (SRVAL_W)
        ) u_bank (
            .clk_i  (clk_i),
            .en_i   (bank_en[b]),
            .we_i   (bus.we),
            .ssr_i  (bus.ssr),
            .addr_i (bank_off),
            .di_i   ({bus.dip, bus.di}),
            .do_o   (bank_do[b])
        );
    end

    always_comb begin
        mux_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (sel_q == BANK_W'(b)) begin
                mux_word = bank_do[b];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.err_clr) begin
            cnt_d = '0;
        end else if (acc_oor && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel_q  <= '0;
            ld1_q  <= 1'b0;
            rv1_q  <= 1'b0;
            err1_q <= 1'b0;
            rv2_q  <= 1'b0;
            err2_q <= 1'b0;
            ok_q   <= 1'b0;
            out_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (acc_load) begin
                sel_q <= bank_idx;
                ok_q  <= 1'b1;
            end
            ld1_q  <= acc_load;
            rv1_q  <= acc_rd;
            err1_q <= acc_oor;
            rv2_q  <= rv1_q;
            err2_q <= err1_q;
            if (ld1_q) begin
                out_q <= mux_word;
            end
            cnt_q <= cnt_d;
        end
    end

    // Bank registers are not reset, so the unregistered path reads zero until a bank is loaded.
    assign dout_word = (OUT_REG != 0) ? out_q : (ok_q ? mux_word : '0);

    assign {bus.doutp, bus.dout} = dout_word;
    assign bus.rd_valid = (OUT_REG != 0) ? rv2_q : rv1_q;
    assign bus.addr_err = (OUT_REG != 0) ? err2_q : err1_q;
    assign bus.err_cnt  = cnt_q;

endmodule

// File: tb/tb_banked_mem.sv
// Drives three banked_mem variants (write modes, latencies, set/reset values)
// with a shared stimulus and checks each against an array-based reference model.
module tb_banked_mem;
    import banked_mem_pkg::*;

    localparam int AW    = 13;
    localparam int DEPTH = 3 * 2048;
    localparam int LAT [3] = '{2, 1, 2};
    localparam int WM  [3] = '{WM_READ_FIRST, WM_WRITE_FIRST, WM_NO_CHANGE};
    localparam logic [8:0] SRV [3] = '{9'h1FF, 9'h000, 9'h0C3};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, we, ssr, err_clr;
    logic [12:0] addr;
    logic [7:0]  di;
    logic        dip;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int rv_cnt0 = 0;

    logic [8:0] mem_m [DEPTH];
    logic       slot_upd [3][4];
    logic [8:0] slot_val [3][4];
    logic       slot_v   [3][4];
    logic       slot_e   [3][4];
    logic [8:0] exp_word [3];
    logic       exp_v    [3];
    logic       exp_e    [3];
    int         exp_cnt;

    always #5 clk = ~clk;

    banked_mem_if #(.DATA_W(8), .PAR_W(1), .ADDR_W(AW), .ERR_W(8)) if0 ();
    banked_mem_if #(.DATA_W(8), .PAR_W(1), .ADDR_W(AW), .ERR_W(8)) if1 ();
    banked_mem_if #(.DATA_W(8), .PAR_W(1), .ADDR_W(AW), .ERR_W(8)) if2 ();

    assign if0.en = en;  assign if0.we = we;  assign if0.ssr = ssr;  assign if0.addr = addr;
    assign if0.di = di;  assign if0.dip = dip; assign if0.err_clr = err_clr;
    assign if1.en = en;  assign if1.we = we;  assign if1.ssr = ssr;  assign if1.addr = addr;
    assign if1.di = di;  assign if1.dip = dip; assign if1.err_clr = err_clr;
    assign if2.en = en;  assign if2.we = we;  assign if2.ssr = ssr;  assign if2.addr = addr;
    assign if2.di = di;  assign if2.dip = dip; assign if2.err_clr = err_clr;

    banked_mem #(.DATA_W(8), .PAR_W(1), .BANK_AW(11), .NUM_BANKS(3), .OUT_REG(1),
                 .WRITE_MODE(WM_READ_FIRST), .SRVAL(32'h1FF), .ERR_W(8))
        u0 (.clk_i(clk), .rst_n_i(rst_n), .bus(if0));
    banked_mem #(.DATA_W(8), .PAR_W(1), .BANK_AW(11), .NUM_BANKS(3), .OUT_REG(0),
                 .WRITE_MODE(WM_WRITE_FIRST), .SRVAL(32'h000), .ERR_W(8))
        u1 (.clk_i(clk), .rst_n_i(rst_n), .bus(if1));
    banked_mem #(.DATA_W(8), .PAR_W(1), .BANK_AW(11), .NUM_BANKS(3), .OUT_REG(1),
                 .WRITE_MODE(WM_NO_CHANGE), .SRVAL(32'h0C3), .ERR_W(8))
        u2 (.clk_i(clk), .rst_n_i(rst_n), .bus(if2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < 4; s++) begin
                slot_upd[d][s] = 1'b0;
                slot_val[d][s] = 9'h0;
                slot_v[d][s]   = 1'b0;
                slot_e[d][s]   = 1'b0;
            end
            exp_word[d] = 9'h0;
            exp_v[d]    = 1'b0;
            exp_e[d]    = 1'b0;
        end
        exp_cnt = 0;
    endtask

    // Each access schedules its visible effect LAT cycles ahead in a small ring.
    task automatic model_access(input int e);
        int         a;
        bit         inr;
        logic [8:0] old_w;
        logic [8:0] new_w;
        a     = int'(addr);
        inr   = (a < DEPTH);
        new_w = {dip, di};
        old_w = inr ? mem_m[a] : 9'h0;
        for (int d = 0; d < 3; d++) begin
            int s;
            s = (e + LAT[d] - 1) % 4;
            if (en) begin
                if (!inr) begin
                    slot_e[d][s] = 1'b1;
                end else if (ssr) begin
                    slot_upd[d][s] = 1'b1;
                    slot_val[d][s] = SRV[d];
                end else if (!we) begin
                    slot_upd[d][s] = 1'b1;
                    slot_val[d][s] = old_w;
                    slot_v[d][s]   = 1'b1;
                end else if (WM[d] == WM_READ_FIRST) begin
                    slot_upd[d][s] = 1'b1;
                    slot_val[d][s] = old_w;
                end else if (WM[d] == WM_WRITE_FIRST) begin
                    slot_upd[d][s] = 1'b1;
                    slot_val[d][s] = new_w;
                end
            end
        end
        if (en && inr && we) mem_m[a] = new_w;
        if (err_clr) exp_cnt = 0;
        else if (en && !inr && exp_cnt < 255) exp_cnt++;
    endtask

    task automatic model_consume(input int e);
        int s;
        s = e % 4;
        for (int d = 0; d < 3; d++) begin
            if (slot_upd[d][s]) exp_word[d] = slot_val[d][s];
            exp_v[d] = slot_v[d][s];
            exp_e[d] = slot_e[d][s];
            slot_upd[d][s] = 1'b0;
            slot_v[d][s]   = 1'b0;
            slot_e[d][s]   = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [8:0] w;
        logic       v, ae;
        logic [7:0] c;
        for (int d = 0; d < 3; d++) begin
            case (d)
                0: begin w = {if0.doutp, if0.dout}; v = if0.rd_valid; ae = if0.addr_err; c = if0.err_cnt; end
                1: begin w = {if1.doutp, if1.dout}; v = if1.rd_valid; ae = if1.addr_err; c = if1.err_cnt; end
                default: begin w = {if2.doutp, if2.dout}; v = if2.rd_valid; ae = if2.addr_err; c = if2.err_cnt; end
            endcase
            chk($sformatf("word%0d@%0d", d, edge_n), 32'(w), 32'(exp_word[d]));
            chk($sformatf("rd_valid%0d@%0d", d, edge_n), 32'(v), 32'(exp_v[d]));
            chk($sformatf("addr_err%0d@%0d", d, edge_n), 32'(ae), 32'(exp_e[d]));
            chk($sformatf("err_cnt%0d@%0d", d, edge_n), 32'(c), 32'(exp_cnt));
        end
        if (if0.rd_valid === 1'b1) rv_cnt0++;
    endtask

    task automatic cycle();
        @(posedge clk);
        edge_n++;
        model_access(edge_n);
        @(negedge clk);
        model_consume(edge_n);
        check_all();
    endtask

    task automatic acc(input logic e, input logic w, input logic [12:0] a,
                       input logic [7:0] d, input logic p);
        en = e; we = w; ssr = 1'b0; addr = a; di = d; dip = p;
        cycle();
    endtask

    task automatic idle(input int n);
        en = 1'b0; we = 1'b0; ssr = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; we = 1'b0; ssr = 1'b0; err_clr = 1'b0;
        addr = '0; di = '0; dip = 1'b0;
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(1);

        for (int b = 0; b < 3; b++)
            for (int o = 0; o < 8; o++)
                acc(1'b1, 1'b1, 13'(b * 2048 + o), 8'($urandom), 1'($urandom));
        idle(2);

        acc(1'b1, 1'b1, 13'h0000, 8'h11, 1'b1);
        acc(1'b1, 1'b1, 13'h0800, 8'h22, 1'b1);
        acc(1'b1, 1'b1, 13'h1000, 8'h33, 1'b1);
        rv_cnt0 = 0;
        acc(1'b1, 1'b0, 13'h0000, 8'h00, 1'b0);
        acc(1'b1, 1'b0, 13'h0800, 8'h00, 1'b0);
        acc(1'b1, 1'b0, 13'h1000, 8'h00, 1'b0);
        idle(3);
        chk("rd_valid_run_len", 32'(rv_cnt0), 32'd3);

        acc(1'b1, 1'b1, 13'h1800, 8'hAA, 1'b0);
        acc(1'b1, 1'b0, 13'h1800, 8'h00, 1'b0);
        idle(2);
        chk("oor_err_cnt", 32'(if0.err_cnt), 32'd2);
        chk("oor_do_hold", 32'(if0.dout), 32'h33);

        acc(1'b1, 1'b1, 13'h0005, 8'h5A, 1'b0);
        acc(1'b1, 1'b0, 13'h0000, 8'h00, 1'b0);
        idle(2);
        acc(1'b1, 1'b1, 13'h0005, 8'hA5, 1'b0);
        idle(2);
        chk("rdw_read_first", 32'(if0.dout), 32'h5A);
        chk("rdw_write_first", 32'(if1.dout), 32'hA5);
        chk("rdw_no_change", 32'(if2.dout), 32'h11);

        en = 1'b1; we = 1'b0; ssr = 1'b1; addr = 13'h0000;
        cycle();
        acc(1'b1, 1'b0, 13'h0000, 8'h00, 1'b0);
        chk("ssr_srval", 32'({if0.doutp, if0.dout}), 32'h1FF);
        idle(1);
        chk("ssr_then_read", 32'({if0.doutp, if0.dout}), 32'h111);
        idle(1);

        for (int i = 0; i < 260; i++)
            acc(1'b1, 1'($urandom), 13'h1800 + 13'($urandom_range(0, 2047)), 8'($urandom), 1'b0);
        idle(2);
        chk("err_saturate", 32'(if0.err_cnt), 32'd255);
        err_clr = 1'b1;
        acc(1'b1, 1'b0, 13'h1900, 8'h00, 1'b0);
        err_clr = 1'b0;
        chk("err_clr_wins", 32'(if0.err_cnt), 32'd0);
        idle(2);

        acc(1'b1, 1'b0, 13'h0800, 8'h00, 1'b0);
        en = 1'b0; rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        idle(2);
        rst_n = 1'b1;
        rv_cnt0 = 0;
        idle(3);
        chk("no_valid_after_reset", 32'(rv_cnt0), 32'd0);
        acc(1'b1, 1'b0, 13'h0800, 8'h00, 1'b0);
        idle(1);
        chk("read_after_reset", 32'(if0.dout), 32'h22);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            we      = 1'($urandom);
            ssr     = ($urandom_range(0, 7) == 0);
            err_clr = ($urandom_range(0, 31) == 0);
            di      = 8'($urandom);
            dip     = 1'($urandom);
            if ($urandom_range(0, 7) == 0)
                addr = 13'h1800 + 13'($urandom_range(0, 2047));
            else
                addr = 13'($urandom_range(0, 2) * 2048 + $urandom_range(0, 7));
            cycle();
        end
        err_clr = 1'b0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/banked_mem.md
Name: banked_mem

Overview:
- Parametrised multi-bank single-port RAM. Successor to the fixed 8-bit x 6144-deep three-bank memory.
- Generalised in data width, parity width, bank depth and bank count. Selectable write mode and output register stage.
- Registered bank-select output mux removes the shared-bus DO contention of the previous generation.
- Out-of-range accesses are flagged and counted. Sits behind the mezzanine-to-FPGA interface as local buffer memory.

Parameters:
- DATA_W, 8, data bits per word
- PAR_W, 1, parity bits per word
- BANK_AW, 11, address bits per bank (depth 2**BANK_AW)
- NUM_BANKS, 3, number of banks, 1..8
- OUT_REG, 1, 0 gives 1-cycle read latency; 1 gives 2-cycle latency with an extra output register
- WRITE_MODE, 0, 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE
- SRVAL, 0, value loaded into {DOP,DO} by SSR
- ERR_W, 8, width of the error counter

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- EN  in  1  access enable
- WE  in  1  write enable, qualified by EN
- SSR  in  1  synchronous output set/reset, qualified by EN
- ADDR  in  ADDR_W  word address; ADDR_W = BANK_AW + clog2(NUM_BANKS), minimum BANK_AW+1
- DI  in  DATA_W  write data
- DIP  in  PAR_W  write parity
- DO  out  DATA_W  read data
- DOP  out  PAR_W  read parity
- RD_VALID  out  1  DO/DOP carry fresh read data this cycle
- ADDR_ERR  out  1  one-cycle pulse, aligned with RD_VALID timing, for an out-of-range access
- ERR_CLR  in  1  synchronous clear of ERR_CNT
- ERR_CNT  out  ERR_W  saturating count of out-of-range accesses

Behaviour:
- Decode: bank = ADDR[ADDR_W-1:BANK_AW]; offset = ADDR[BANK_AW-1:0]. Bank enable is one-hot, and only when EN=1 and bank < NUM_BANKS.
- Out of range (EN=1, bank >= NUM_BANKS):
  - no bank is enabled and nothing is written
  - ADDR_ERR pulses at read-data time
  - RD_VALID stays 0 and DO/DOP hold their value
  - ERR_CNT increments, saturating at all-ones
- Reset: asynchronous on RST_N=0. DO, DOP, RD_VALID, ADDR_ERR, ERR_CNT and all pipeline registers go to 0. Memory array contents are not reset.
- Read (EN=1, WE=0, in range):
  - bank output register captures mem[offset] at edge N
  - the bank index is registered alongside
  - OUT_REG=0: DO/DOP = selected bank output and RD_VALID=1 in cycle N+1
  - OUT_REG=1: the mux output is registered again; data and RD_VALID appear in cycle N+2
- Write (EN=1, WE=1, in range):
  - mem[offset] <= {DIP,DI} at the edge
  - READ_FIRST: the output path carries the old word
  - WRITE_FIRST: the output path carries the new word
  - NO_CHANGE: DO/DOP hold
  - RD_VALID=0 for every write
- SSR (EN=1): the bank output stage loads SRVAL instead of read data. A write in the same cycle still updates memory. RD_VALID=0. With OUT_REG=1, the output register also loads SRVAL one cycle later.
- EN=0: no array access. Pipelines advance; RD_VALID=0, ADDR_ERR=0, DO/DOP hold.
- Back-to-back accesses at one per cycle are fully pipelined, with no stall or bubble.
- ERR_CLR and an out-of-range access in the same cycle: the clear wins, and ERR_CNT becomes 0.
- Reset mid-read: the in-flight read is discarded and no RD_VALID is produced after release.
- Address wrap: offset all-ones in bank k is followed by offset 0 in bank k+1. There is no implicit wrap; the caller supplies ADDR.

Decomposition:
- Package banked_mem_pkg holds:
  - WRITE_MODE encodings (WM_READ_FIRST=0, WM_WRITE_FIRST=1, WM_NO_CHANGE=2)
  - clog2 function
  - ADDR_W derivation
- One sub-module, mem_bank:
  - single inferred RAM of 2**BANK_AW x (DATA_W+PAR_W)
  - ports CLK, EN, WE, SSR, ADDR, DI, DO
  - implements WRITE_MODE and SRVAL
  - instantiated NUM_BANKS times in a generate loop
- The top level owns decode, bank-index pipeline, output mux, OUT_REG stage, error logic and counter.

Test Plan:
- Defaults: write 0x11 to ADDR 0x0000, 0x22 to 0x0800, 0x33 to 0x1000, DIP=1, then read all three back-to-back -> DO = 0x11, 0x22, 0x33 with DOP=1 on three consecutive cycles, starting 2 cycles after the first read; RD_VALID high for exactly 3 cycles.
- Access ADDR 0x1800 (bank 3, out of range) with WE=1, DI=0xAA, then read 0x1800 -> ADDR_ERR pulses twice, ERR_CNT=2, no bank write, RD_VALID=0, DO holds 0x33.
- Read-during-write at 0x0005 (old 0x5A, new 0xA5) -> DO=0x5A for WRITE_MODE=0, 0xA5 for WRITE_MODE=1, previous DO for WRITE_MODE=2; RD_VALID=0 in all three modes.
- SSR with EN=1, SRVAL=0x1FF and OUT_REG=1 -> {DOP,DO}=0x1FF two cycles later; a following read of 0x0000 returns 0x11.
- Saturation: 260 out-of-range accesses with ERR_W=8 -> ERR_CNT=255. ERR_CLR together with one more out-of-range access -> ERR_CNT=0.
- Reset mid-operation: assert RST_N=0 one cycle after issuing a read of 0x0800 -> DO=0, RD_VALID stays 0 after release; a subsequent read of 0x0800 returns 0x22.
